// File: rtl/ecs8_owr_mst.sv
// 1-wire bus master: one slot (write 0/1, read, reset/presence) per command on one of OWN channels.
// Slot timing is counted in time-base ticks of CDR_N (normal) or CDR_O (overdrive) clk cycles.
module ecs8_owr_mst #(
   parameter int OWN   = 1,
   parameter int CDR_N = 33,
   parameter int CDR_O = 4,
   localparam int SW   = (OWN > 1) ? $clog2(OWN) : 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic [1:0]     cmd_op,
   input  logic [SW-1:0]  cmd_sel,
   input  logic           cmd_ovd,
   input  logic           cmd_pwr,
   output logic           rsp_valid,
   output logic           rsp_data,
   output logic [OWN-1:0] owr_e,
   output logic [OWN-1:0] owr_p,
   input  logic [OWN-1:0] owr_i
);
   localparam int CDR_MAX = (CDR_N > CDR_O) ? CDR_N : CDR_O;
   localparam int PW      = $clog2(CDR_MAX + 1);
   localparam logic [PW-1:0] CDR_N_M1 = PW'(CDR_N - 1);
   localparam logic [PW-1:0] CDR_O_M1 = PW'(CDR_O - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, RSP = 2'd2} state_t;

   state_t          state, state_nx;
   logic [PW-1:0]   pre, pre_nx;
   logic [9:0]      t, t_nx, t_inc;
   logic [1:0]      op_q, op_nx;
   logic [SW-1:0]   sel_q, sel_nx;
   logic            ovd_q, pwr_q;
   logic [OWN-1:0]  sync1, sync2;
   logic [OWN-1:0]  sel_oh, sel_oh_nx;
   logic [OWN-1:0]  owr_e_nx, owr_p_nx;
   logic            smp, smp_en, fin, tick, accept, e_on, rsp_nx;
   logic [PW-1:0]   cdr_m1;

   function automatic logic [9:0] f_low(input logic [1:0] op);
      case (op)
         2'b00:   f_low = 10'd60;
         2'b11:   f_low = 10'd480;
         default: f_low = 10'd6;
      endcase
   endfunction

   function automatic logic [9:0] f_smp(input logic [1:0] op);
      f_smp = (op == 2'b11) ? 10'd550 : 10'd15;
   endfunction

   function automatic logic [9:0] f_end(input logic [1:0] op);
      f_end = (op == 2'b11) ? 10'd960 : 10'd64;
   endfunction

   assign cmd_ready = (state == IDLE);
   assign rsp_valid = (state == RSP);
   assign accept    = cmd_valid && (state == IDLE);
   assign cdr_m1    = ovd_q ? CDR_O_M1 : CDR_N_M1;
   assign tick      = (pre == cdr_m1);
   assign t_inc     = t + 10'd1;

   always_comb begin
      op_nx  = op_q;
      sel_nx = sel_q;
      if (accept) begin
         op_nx  = cmd_op;
         sel_nx = cmd_sel;
      end
      for (int i = 0; i < OWN; i++) begin
         sel_oh[i]    = (sel_q == SW'(i));
         sel_oh_nx[i] = (sel_nx == SW'(i));
      end
   end

   always_comb begin
      state_nx = state;
      pre_nx   = pre;
      t_nx     = t;
      smp_en   = 1'b0;
      fin      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nx = RUN;
               pre_nx   = '0;
               t_nx     = '0;
            end
         end
         RUN: begin
            if (tick) begin
               pre_nx = '0;
               t_nx   = t_inc;
               smp_en = (t_inc == f_smp(op_q));
               if (t_inc == f_end(op_q)) begin
                  state_nx = RSP;
                  fin      = 1'b1;
               end
            end else begin
               pre_nx = pre + PW'(1);
            end
         end
         RSP:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Out-of-range selects match no one-hot bit, so they drive nothing and report 0.
   always_comb begin
      e_on     = (state_nx == RUN) && (t_nx < f_low(op_nx));
      owr_e_nx = e_on ? sel_oh_nx : '0;
      owr_p_nx = owr_p;
      if (accept)
         owr_p_nx = '0;
      else if (fin && pwr_q)
         owr_p_nx = owr_p | sel_oh;
      rsp_nx = rsp_data;
      if (fin)
         rsp_nx = (|sel_oh) & ((op_q == 2'b11) ? ~smp : smp);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pre      <= '0;
         t        <= '0;
         sync1    <= '0;
         sync2    <= '0;
         owr_e    <= '0;
         owr_p    <= '0;
         rsp_data <= 1'b0;
      end else begin
         state    <= state_nx;
         pre      <= pre_nx;
         t        <= t_nx;
         sync1    <= owr_i;
         sync2    <= sync1;
         owr_e    <= owr_e_nx;
         owr_p    <= owr_p_nx;
         rsp_data <= rsp_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         op_q  <= cmd_op;
         sel_q <= cmd_sel;
         ovd_q <= cmd_ovd;
         pwr_q <= cmd_pwr;
      end
      if (smp_en)
         smp <= |(sync2 & sel_oh);
   end
endmodule
